// File: rtl/canny_gradient_core_p.sv
// canny_gradient_core_p
//   Canny gradient stage between the 3x3 window generator and NMS/hysteresis.
//   Computes Sobel Gx/Gy, gradient magnitude (floor integer sqrt, one result bit per
//   pipeline stage), a 4-way direction and a weak/strong class against per-frame
//   thresholds. Also publishes the strong-pixel count of the last completed frame.
//   Free-running, no stall; latency LAT = MAG_W + 4 cycles from win to out_*.
//
// Build option:
//   CANNY_GRAD_L1_EN  defined -> magnitude is min(|Gx|+|Gy|, 2^MAG_W-1), the sqrt stages
//                     become a plain delay line; latency, direction, class and count
//                     are unchanged. Undefined -> exact floor(sqrt(Gx^2+Gy^2)).
//
// Ports:
//   clk, rst_s       clock; asynchronous active-low reset (synchronous release)
//   in_vs/hs/de      frame / line / pixel valid
//   win              p11..p33 packed row-major, p11 at LSBs
//   th_low, th_high  weak / strong thresholds, captured on the rising edge of in_vs
//   out_vs/hs/de     syncs delayed by LAT
//   out_mag          gradient magnitude (0 when out_de is low)
//   out_dir          0 horiz, 1 diag same-sign, 2 vert, 3 diag opposite-sign
//   out_cls          00 none, 01 weak, 10 strong
//   frame_strong     saturating strong-pixel count of the last completed frame
module canny_gradient_core_p #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CNT_W = 20
) (
  input  logic               clk,
  input  logic               rst_s,
  input  logic               in_vs,
  input  logic               in_hs,
  input  logic               in_de,
  input  logic [9*PIX_W-1:0] win,
  input  logic [PIX_W+2:0]   th_low,
  input  logic [PIX_W+2:0]   th_high,
  output logic               out_vs,
  output logic               out_hs,
  output logic               out_de,
  output logic [PIX_W+2:0]   out_mag,
  output logic [1:0]         out_dir,
  output logic [1:0]         out_cls,
  output logic [CNT_W-1:0]   frame_strong
);

  localparam int unsigned MAG_W = PIX_W + 3;
  localparam int unsigned SUM_W = PIX_W + 2;
  localparam int unsigned CMP_W = PIX_W + 4;
  localparam int unsigned LAT   = MAG_W + 4;

  // Reset synchroniser: assertion is immediate, release is aligned to clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Window unpack
  logic [PIX_W-1:0] p [9];
  always_comb begin
    for (int i = 0; i < 9; i++) p[i] = win[i*PIX_W +: PIX_W];
  end

  // S1: positive/negative partial sums, S2: magnitude and sign (1 = negative)
  logic [SUM_W-1:0] gxp_q, gxn_q, gyp_q, gyn_q;
  logic [SUM_W-1:0] ax_q, ay_q;
  logic             sx_q, sy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gxp_q <= '0;
      gxn_q <= '0;
      gyp_q <= '0;
      gyn_q <= '0;
      ax_q  <= '0;
      ay_q  <= '0;
      sx_q  <= 1'b0;
      sy_q  <= 1'b0;
    end else begin
      gxp_q <= SUM_W'(p[2]) + SUM_W'({p[5], 1'b0}) + SUM_W'(p[8]);
      gxn_q <= SUM_W'(p[0]) + SUM_W'({p[3], 1'b0}) + SUM_W'(p[6]);
      gyp_q <= SUM_W'(p[6]) + SUM_W'({p[7], 1'b0}) + SUM_W'(p[8]);
      gyn_q <= SUM_W'(p[0]) + SUM_W'({p[1], 1'b0}) + SUM_W'(p[2]);
      ax_q  <= (gxp_q >= gxn_q) ? gxp_q - gxn_q : gxn_q - gxp_q;
      ay_q  <= (gyp_q >= gyn_q) ? gyp_q - gyn_q : gyn_q - gyp_q;
      sx_q  <= (gxp_q < gxn_q);
      sy_q  <= (gyp_q < gyn_q);
    end
  end

  // S3 direction: tan(22.5 deg) boundaries approximated by 2.5x in full CMP_W width.
  logic [CMP_W-1:0] ax_w, ay_w;
  logic [1:0]       dir_s3;

  always_comb begin
    ax_w = CMP_W'(ax_q);
    ay_w = CMP_W'(ay_q);
    if (ax_q == '0 && ay_q == '0) begin
      dir_s3 = 2'd0;  // zero gradient has no orientation, report as horizontal
    end else if (ax_w > (ay_w << 1) + (ay_w >> 1)) begin
      dir_s3 = 2'd0;
    end else if (ay_w > (ax_w << 1) + (ax_w >> 1)) begin
      dir_s3 = 2'd2;
    end else if (sx_q == sy_q) begin
      dir_s3 = 2'd1;
    end else begin
      dir_s3 = 2'd3;
    end
  end

  // Stage index 0 is the S3 register; stages 1..MAG_W each settle one magnitude bit.
  logic [MAG_W-1:0] root_q [MAG_W+1];
  logic [1:0]       dir_q  [MAG_W+1];

`ifdef CANNY_GRAD_L1_EN
  logic [MAG_W:0]   l1_sum;
  logic [MAG_W-1:0] l1_mag;

  always_comb begin
    l1_sum = (MAG_W+1)'(ax_q) + (MAG_W+1)'(ay_q);
    l1_mag = l1_sum[MAG_W] ? {MAG_W{1'b1}} : l1_sum[MAG_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= MAG_W; k++) begin
        root_q[k] <= '0;
        dir_q[k]  <= 2'd0;
      end
    end else begin
      root_q[0] <= l1_mag;
      dir_q[0]  <= dir_s3;
      for (int k = 1; k <= MAG_W; k++) begin
        root_q[k] <= root_q[k-1];
        dir_q[k]  <= dir_q[k-1];
      end
    end
  end
`else
  localparam int unsigned SQ_W  = 2*PIX_W + 5;
  localparam int unsigned RAD_W = 2*MAG_W;
  localparam int unsigned REM_W = MAG_W + 5;

  // Non-restoring step: a negative remainder is not restored but corrected on the
  // next step by adding (4q+3) instead of subtracting (4q+1).
  function automatic logic signed [REM_W-1:0] sqrt_step(
    input logic signed [REM_W-1:0] rem,
    input logic [1:0]              bits,
    input logic [MAG_W-1:0]        root
  );
    logic signed [REM_W-1:0] sh;
    logic signed [REM_W-1:0] q4;
    sh = {rem[REM_W-3:0], bits};
    q4 = {{(REM_W-MAG_W-2){1'b0}}, root, 2'b00};
    if (rem[REM_W-1]) return sh + (q4 | REM_W'(3));
    else              return sh - (q4 | REM_W'(1));
  endfunction

  logic [SQ_W-1:0]         sq_s3;
  logic [RAD_W-1:0]        rad_q [MAG_W];
  logic signed [REM_W-1:0] rem_q [MAG_W];
  logic signed [REM_W-1:0] rem_d [1:MAG_W];

  assign sq_s3 = SQ_W'(ax_q) * SQ_W'(ax_q) + SQ_W'(ay_q) * SQ_W'(ay_q);

  always_comb begin
    for (int k = 1; k <= MAG_W; k++) begin
      rem_d[k] = sqrt_step(rem_q[k-1], rad_q[k-1][2*(MAG_W-k) +: 2], root_q[k-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= MAG_W; k++) begin
        root_q[k] <= '0;
        dir_q[k]  <= 2'd0;
      end
      for (int k = 0; k < MAG_W; k++) begin
        rad_q[k] <= '0;
        rem_q[k] <= '0;
      end
    end else begin
      root_q[0] <= '0;
      dir_q[0]  <= dir_s3;
      rad_q[0]  <= RAD_W'(sq_s3);
      rem_q[0]  <= '0;
      for (int k = 1; k <= MAG_W; k++) begin
        root_q[k] <= {root_q[k-1][MAG_W-2:0], ~rem_d[k][REM_W-1]};
        dir_q[k]  <= dir_q[k-1];
      end
      for (int k = 1; k < MAG_W; k++) begin
        rad_q[k] <= rad_q[k-1];
        rem_q[k] <= rem_d[k];
      end
    end
  end
`endif

  // Sync delay lines (LAT-1 deep, the output register supplies the last cycle).
  // tag marks pixels of a frame whose start was seen after reset, so a frame cut by
  // reset never publishes a partial count.
  logic [LAT-2:0]   vs_sr, hs_sr, de_sr, tag_sr;
  logic             seen_low_q;
  logic [MAG_W-1:0] th_low_s, th_high_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sr      <= '0;
      hs_sr      <= '0;
      de_sr      <= '0;
      tag_sr     <= '0;
      seen_low_q <= 1'b0;
      th_low_s   <= '0;
      th_high_s  <= '0;
    end else begin
      vs_sr  <= {vs_sr[LAT-3:0], in_vs};
      hs_sr  <= {hs_sr[LAT-3:0], in_hs};
      de_sr  <= {de_sr[LAT-3:0], in_de};
      tag_sr <= {tag_sr[LAT-3:0], in_vs & seen_low_q};
      if (!in_vs) seen_low_q <= 1'b1;
      // vs_sr[0] is in_vs one cycle ago
      if (in_vs && !vs_sr[0]) begin
        th_low_s  <= th_low;
        th_high_s <= th_high;
      end
    end
  end

  // Final stage: classify and register outputs
  logic [MAG_W-1:0] mag_f;
  logic             de_f;
  logic [1:0]       cls_f;

  assign mag_f = root_q[MAG_W];
  assign de_f  = de_sr[LAT-2];

  always_comb begin
    cls_f = 2'b00;
    if (mag_f > th_high_s)     cls_f = 2'b10;
    else if (mag_f > th_low_s) cls_f = 2'b01;
  end

  logic out_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vs    <= 1'b0;
      out_hs    <= 1'b0;
      out_de    <= 1'b0;
      out_mag   <= '0;
      out_dir   <= 2'd0;
      out_cls   <= 2'b00;
      out_tag_q <= 1'b0;
    end else begin
      out_vs    <= vs_sr[LAT-2];
      out_hs    <= hs_sr[LAT-2];
      out_de    <= de_f;
      out_mag   <= de_f ? mag_f : '0;
      out_dir   <= de_f ? dir_q[MAG_W] : 2'd0;
      out_cls   <= de_f ? cls_f : 2'b00;
      out_tag_q <= tag_sr[LAT-2];
    end
  end

  // Strong-pixel counter. The falling edge is detected as out_vs is about to drop, so
  // the pixel currently on the outputs (last of the frame) is still included.
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             vs_fall, strong_px;

  always_comb begin
    vs_fall   = out_vs & ~vs_sr[LAT-2];
    strong_px = out_de & (out_cls == 2'b10);
    cnt_inc   = (strong_px && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      frame_strong <= '0;
    end else if (vs_fall) begin
      cnt_q <= '0;
      if (out_tag_q) frame_strong <= cnt_inc;
    end else begin
      cnt_q <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_canny_gradient_core_p.sv
// Directed bench for canny_gradient_core_p (PIX_W=8, LAT=15). A negedge monitor pops
// hand-computed expectations for every output pixel; frame-level checks cover
// latency, threshold shadowing, the strong counter (also with CNT_W=3) and reset.
module tb_canny_gradient_core_p;

  localparam int LAT = 15;

`ifdef CANNY_GRAD_L1_EN
  localparam int MAG_DIAG = 800;
  localparam int MAG_75   = 76;
`else
  localparam int MAG_DIAG = 565;
  localparam int MAG_75   = 75;
`endif

  // Windows written {p33,p32,p31, p23,p22,p21, p13,p12,p11} so p11 lands at the LSBs.
  localparam logic [71:0] W_FLAT  = {9{8'd100}};
  localparam logic [71:0] W_HORIZ = {8'd255, 8'd128, 8'd0, 8'd255, 8'd128, 8'd0,
                                     8'd255, 8'd128, 8'd0};                    // Gx=1020
  localparam logic [71:0] W_VERT  = {8'd255, 8'd255, 8'd255, 8'd128, 8'd128, 8'd128,
                                     8'd0, 8'd0, 8'd0};                        // Gy=1020
  localparam logic [71:0] W_DIAGP = {8'd200, 8'd100, 8'd0, 8'd100, 8'd0, 8'd0,
                                     8'd0, 8'd0, 8'd0};                        // +400,+400
  localparam logic [71:0] W_DIAGN = {8'd0, 8'd0, 8'd0, 8'd100, 8'd0, 8'd0,
                                     8'd200, 8'd100, 8'd0};                    // +400,-400
  localparam logic [71:0] W_75    = {8'd1, 8'd0, 8'd0, 8'd37, 8'd0, 8'd0,
                                     8'd0, 8'd0, 8'd0};                        // Gx=75,Gy=1
  localparam logic [71:0] W_150   = {8'd0, 8'd0, 8'd0, 8'd75, 8'd0, 8'd0,
                                     8'd0, 8'd0, 8'd0};                        // Gx=150
  localparam logic [71:0] W_90    = {8'd0, 8'd0, 8'd0, 8'd45, 8'd0, 8'd0,
                                     8'd0, 8'd0, 8'd0};                        // Gx=90

  logic        clk = 1'b0;
  logic        rst_s, in_vs, in_hs, in_de;
  logic [71:0] win;
  logic [10:0] th_low, th_high;
  logic        out_vs, out_hs, out_de;
  logic [10:0] out_mag;
  logic [1:0]  out_dir, out_cls;
  logic [19:0] frame_strong;
  logic        s_vs, s_hs, s_de;
  logic [10:0] s_mag;
  logic [1:0]  s_dir, s_cls;
  logic [2:0]  s_frame_strong;

  canny_gradient_core_p #(.PIX_W(8), .CNT_W(20)) dut (
    .clk(clk), .rst_s(rst_s), .in_vs(in_vs), .in_hs(in_hs), .in_de(in_de), .win(win),
    .th_low(th_low), .th_high(th_high), .out_vs(out_vs), .out_hs(out_hs),
    .out_de(out_de), .out_mag(out_mag), .out_dir(out_dir), .out_cls(out_cls),
    .frame_strong(frame_strong)
  );

  canny_gradient_core_p #(.PIX_W(8), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_s(rst_s), .in_vs(in_vs), .in_hs(in_hs), .in_de(in_de), .win(win),
    .th_low(th_low), .th_high(th_high), .out_vs(s_vs), .out_hs(s_hs),
    .out_de(s_de), .out_mag(s_mag), .out_dir(s_dir), .out_cls(s_cls),
    .frame_strong(s_frame_strong)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] mag;
    logic [1:0]  dir;
    logic [1:0]  cls;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_px;
  bit   mon_en;
  int   n_checks;
  int   n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Output monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_de) begin
        if (exp_q.size() == 0) begin
          check("px_queue", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_px = exp_q.pop_front();
          check("mag", 32'(out_mag), 32'(exp_px.mag));
          check("dir", 32'(out_dir), 32'(exp_px.dir));
          check("cls", 32'(out_cls), 32'(exp_px.cls));
          check("hs_with_de", 32'(out_hs), 32'd1);
          check("vs_with_de", 32'(out_vs), 32'd1);
        end
      end else begin
        check("idle_zero", 32'({out_mag, out_dir, out_cls}), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [71:0] w, input int mag, input int dir, input int cls);
    win   = w;
    in_de = 1'b1;
    in_hs = 1'b1;
    if (mon_en) exp_q.push_back('{mag: 11'(mag), dir: 2'(dir), cls: 2'(cls)});
    tick();
    in_de = 1'b0;
    in_hs = 1'b0;
  endtask

  task automatic frame_begin(input int lo, input int hi);
    th_low  = 11'(lo);
    th_high = 11'(hi);
    in_vs   = 1'b1;
    tick();
    tick();
  endtask

  task automatic frame_end();
    in_vs = 1'b0;
    repeat (LAT + 6) tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    rst_s    = 1'b0;
    in_vs    = 1'b0;
    in_hs    = 1'b0;
    in_de    = 1'b0;
    win      = '0;
    th_low   = 11'd50;
    th_high  = 11'd100;
    repeat (3) tick();
    check("rst_vs", 32'(out_vs), 32'd0);
    check("rst_de", 32'(out_de), 32'd0);
    check("rst_mag", 32'(out_mag), 32'd0);
    check("rst_cls", 32'(out_cls), 32'd0);
    check("rst_frame_strong", 32'(frame_strong), 32'd0);
    rst_s = 1'b1;
    repeat (4) tick();
    mon_en = 1'b1;

    // F0: latency/alignment, then one pixel per direction
    in_vs = 1'b1;
    repeat (LAT - 1) tick();
    check("vs_lat_early", 32'(out_vs), 32'd0);
    tick();
    check("vs_lat", 32'(out_vs), 32'd1);
    pix(W_FLAT, 0, 0, 0);
    repeat (LAT - 2) tick();
    check("de_lat_early", 32'(out_de), 32'd0);
    tick();
    check("de_lat", 32'(out_de), 32'd1);
    check("hs_lat", 32'(out_hs), 32'd1);
    pix(W_HORIZ, 1020, 0, 2);
    pix(W_VERT, 1020, 2, 2);
    pix(W_DIAGP, MAG_DIAG, 1, 2);
    pix(W_DIAGN, MAG_DIAG, 3, 2);
    frame_end();
    check("f0_count", 32'(frame_strong), 32'd4);
    check("f0_count_sat", 32'(s_frame_strong), 32'd4);

    // F1: weak pixel, th_high lowered mid-frame must not apply yet
    frame_begin(50, 100);
    pix(W_75, MAG_75, 0, 1);
    th_high = 11'd60;
    tick();
    pix(W_75, MAG_75, 0, 1);
    frame_end();
    check("f1_count", 32'(frame_strong), 32'd0);

    // F2: new threshold takes effect
    frame_begin(50, 60);
    pix(W_75, MAG_75, 0, 2);
    frame_end();
    check("f2_count", 32'(frame_strong), 32'd1);

    // F3: th_low above th_high -> only strong or none
    frame_begin(200, 100);
    pix(W_150, 150, 0, 2);
    pix(W_90, 90, 0, 0);
    frame_end();
    check("f3_count", 32'(frame_strong), 32'd1);

    // F4: frame with no pixels publishes 0
    frame_begin(50, 100);
    repeat (5) tick();
    frame_end();
    check("empty_count", 32'(frame_strong), 32'd0);

    // F5: 10 strong + 5 weak; narrow counter saturates at 7
    frame_begin(50, 100);
    for (int i = 0; i < 10; i++) begin
      pix(W_HORIZ, 1020, 0, 2);
      if (i < 5) pix(W_75, MAG_75, 0, 1);
      tick();
    end
    frame_end();
    check("f5_count", 32'(frame_strong), 32'd10);
    check("f5_count_sat", 32'(s_frame_strong), 32'd7);

    // F6: reset for one cycle mid-frame while strong pixels are on the outputs
    mon_en = 1'b0;
    frame_begin(50, 100);
    for (int i = 0; i < 17; i++) pix(W_HORIZ, 1020, 0, 2);
    check("pre_rst_de", 32'(out_de), 32'd1);
    check("pre_rst_mag", 32'(out_mag), 32'd1020);
    rst_s = 1'b0;
    #1;
    check("mid_rst_vs", 32'(out_vs), 32'd0);
    check("mid_rst_de", 32'(out_de), 32'd0);
    check("mid_rst_mag", 32'(out_mag), 32'd0);
    check("mid_rst_cls", 32'(out_cls), 32'd0);
    check("mid_rst_count", 32'(frame_strong), 32'd0);
    check("mid_rst_count_sat", 32'(s_frame_strong), 32'd0);
    tick();
    rst_s = 1'b1;
    for (int i = 0; i < 8; i++) pix(W_HORIZ, 1020, 0, 2);
    frame_end();
    check("partial_count", 32'(frame_strong), 32'd0);
    check("partial_count_sat", 32'(s_frame_strong), 32'd0);

    // F7: first full frame after reset counts normally
    mon_en = 1'b1;
    frame_begin(50, 100);
    for (int i = 0; i < 3; i++) pix(W_VERT, 1020, 2, 2);
    for (int i = 0; i < 2; i++) pix(W_75, MAG_75, 0, 1);
    frame_end();
    check("f7_count", 32'(frame_strong), 32'd3);
    check("f7_count_sat", 32'(s_frame_strong), 32'd3);
    check("px_left", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
